// File: rtl/dot_product_pipe.sv
// Pipelined LANES-wide dot product: input register, per-lane multiply, registered
// binary adder tree, then an accumulate/output stage with valid/ready on both sides.
module dot_product_pipe #(
  parameter int  WIDTH   = 32,
  parameter int  LANES   = 4,
  parameter int  ACC_EXT = 8,
  localparam int LG      = $clog2(LANES),
  localparam int OUT_W   = 2 * WIDTH + LG + ACC_EXT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_signed,
  input  logic                   in_acc,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data
);

  localparam int PW = 2 * WIDTH;
  // Pipeline slots ahead of stage A: input register, product register, LG tree levels.
  localparam int NS = LG + 2;

  logic                   w_en;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_b;
  logic                   r_sgn;
  logic [NS-1:0]          r_vld;
  logic [NS-1:0]          r_acc_flag;
  logic [NS-1:0]          r_last_flag;
  logic [OUT_W-1:0]       r_tree [LG+1][LANES];

  logic signed [WIDTH:0]  w_a_x  [LANES];
  logic signed [WIDTH:0]  w_b_x  [LANES];
  logic signed [PW-1:0]   w_p    [LANES];
  logic [OUT_W-1:0]       w_prod [LANES];

  logic                   w_beat_v;
  logic                   w_beat_acc;
  logic                   w_beat_last;
  logic                   w_emit;
  logic [OUT_W-1:0]       w_base;
  logic [OUT_W-1:0]       w_sum_in;
  logic [OUT_W-1:0]       r_acc_sum;
  logic                   r_acc_open;
  logic [OUT_W-1:0]       r_out_data;
  logic                   r_out_valid;

  // Whole pipeline advances together; a full, unaccepted output freezes every stage.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // NOTE: combinational logic uses blocking '=' so each lane's value is visible
  // immediately within the same evaluation; only clocked state uses '<='.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      // One extra operand bit lets a single signed multiplier cover both modes.
      w_a_x[l]  = {r_sgn & r_a[l*WIDTH+WIDTH-1], r_a[l*WIDTH +: WIDTH]};
      w_b_x[l]  = {r_sgn & r_b[l*WIDTH+WIDTH-1], r_b[l*WIDTH +: WIDTH]};
      w_p[l]    = PW'(w_a_x[l]) * PW'(w_b_x[l]);
      w_prod[l] = {{(OUT_W-PW){r_sgn & w_p[l][PW-1]}}, w_p[l]};
    end
  end

  assign w_beat_v    = r_vld[NS-1];
  assign w_beat_acc  = r_acc_flag[NS-1];
  assign w_beat_last = r_last_flag[NS-1];
  assign w_emit      = w_beat_v && (!w_beat_acc || w_beat_last);
  // A plain beat ignores any open group so its own dot product is what comes out.
  assign w_base      = (r_acc_open && w_beat_acc) ? r_acc_sum : '0;
  assign w_sum_in    = w_base + r_tree[LG][0];

  // NOTE: datapath and sideband registers carry no reset; they are only ever
  // consumed when qualified by the reset-cleared valid bits.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_a         <= in_a;
      r_b         <= in_b;
      r_sgn       <= in_signed;
      r_acc_flag  <= {r_acc_flag[NS-2:0], in_acc};
      r_last_flag <= {r_last_flag[NS-2:0], in_last};
      for (int l = 0; l < LANES; l++) begin
        r_tree[0][l] <= w_prod[l];
      end
      for (int s = 1; s <= LG; s++) begin
        for (int j = 0; j < (LANES >> s); j++) begin
          r_tree[s][j] <= r_tree[s-1][2*j] + r_tree[s-1][2*j+1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= '0;
      r_acc_sum   <= '0;
      r_acc_open  <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_vld       <= {r_vld[NS-2:0], in_valid};
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_data <= w_sum_in;
      end
      if (w_beat_v) begin
        if (w_beat_acc && !w_beat_last) begin
          r_acc_sum  <= w_sum_in;
          r_acc_open <= 1'b1;
        end else begin
          r_acc_open <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_dot_product_pipe.sv
// Scoreboard bench for dot_product_pipe: two instances (ACC_EXT=8 and ACC_EXT=4)
// receive identical beats; a monitor compares every handed-off result in order.
module tb_dot_product_pipe;

  localparam int WIDTH  = 8;
  localparam int LANES  = 4;
  localparam int LG     = 2;
  localparam int OUT_W  = 2 * WIDTH + LG + 8;
  localparam int OUT_WN = 2 * WIDTH + LG + 4;
  localparam longint MASK_W = (longint'(1) << OUT_W) - 1;
  localparam longint MASK_N = (longint'(1) << OUT_WN) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_signed = 1'b0;
  logic in_acc = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [LANES*WIDTH-1:0] in_a = '0;
  logic [LANES*WIDTH-1:0] in_b = '0;
  logic in_ready, out_valid, in_ready_n, out_valid_n;
  logic [OUT_W-1:0]  out_data;
  logic [OUT_WN-1:0] out_data_n;

  int n_checks = 0;
  int n_fail = 0;
  longint sb[$];

  always #5 clk = ~clk;

  dot_product_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_EXT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  dot_product_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_EXT(4)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
    .in_last(in_last), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_data(out_data_n)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Lane 0 sits in the low byte.
  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  // Drive one beat from a falling edge and hold it until accepted on a rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                      input bit acc, input bit last, input bit push, input longint e);
    int n = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_signed = sgn; in_acc = acc; in_last = last; in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 50) begin
        check("accept_timeout", n, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // Monitor: a result is taken on the next rising edge when valid and ready are both high.
  initial begin
    longint e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d, expected none", out_data);
        end else begin
          e = sb.pop_front();
          check("result", longint'(out_data), e & MASK_W);
          check("valid_narrow", longint'(out_valid_n), 1);
          check("result_narrow", longint'(out_data_n), e & MASK_N);
        end
      end
    end
  end

  initial begin
    int bp_exp [6] = '{5, 7, 9, 11, 13, 15};

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid_after", out_valid, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_in_ready", in_ready, 1);

    // Plain beat and its latency
    send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, 0, 0, 1, 70);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_cycle%0d", c), out_valid, (c == 4) ? 1 : 0);
    end
    drain();

    // Back-to-back plain beats
    send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, 0, 0, 1, 70);
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 0, 0, 1, 10);
    send(pack4(255, 255, 255, 255), pack4(255, 255, 255, 255), 0, 0, 0, 1, 260100);
    drain();

    // Signed, same bits unsigned, signed extremes
    send(pack4(-1, -2, 3, 4), pack4(5, 6, -7, 8), 1, 0, 0, 1, -6);
    send(pack4(-1, -2, 3, 4), pack4(5, 6, -7, 8), 0, 0, 0, 1, 3578);
    send(pack4(-128, 127, -128, 127), pack4(-128, -128, 127, 127), 1, 0, 0, 1, 1);
    drain();

    // Accumulation group of three, then a fresh group, then a mixed-sign group
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 1, 0, 0, 0);
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 1, 0, 0, 0);
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 1, 1, 1, 30);
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 1, 1, 1, 10);
    send(pack4(-1, 0, 0, 0), pack4(1, 0, 0, 0), 1, 1, 0, 0, 0);
    send(pack4(255, 0, 0, 0), pack4(1, 0, 0, 0), 0, 1, 1, 1, 254);
    drain();

    // 17 beats of 4*255*255: 4421700 wide, 227396 in the 22-bit instance
    for (int i = 0; i < 17; i++) begin
      send(pack4(255, 255, 255, 255), pack4(255, 255, 255, 255), 0, 1, (i == 16), (i == 16), 4421700);
    end
    drain();

    // Backpressure: hold out_ready low for 3 cycles while the first result waits
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(pack4(i + 1, 1, 0, 0), pack4(2, 3, 0, 0), 0, 0, 0, 1, bp_exp[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : bp
        int n;
        logic [OUT_W-1:0] held;
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b0;
        held = out_data;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          #1;
          check("bp_in_ready", in_ready, 0);
          check("bp_hold_valid", out_valid, 1);
          check("bp_hold_data", longint'(out_data), longint'(held));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with an open accumulation group
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 1, 0, 0, 0);
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 1, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", longint'(out_data), 0);
    check("midrst_out_data_narrow", longint'(out_data_n), 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    send(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 0, 1, 1, 1, 10);
    send(pack4(2, 0, 0, 0), pack4(3, 0, 0, 0), 0, 0, 0, 1, 6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
